// File: rtl/cv32e40x_lsu_wb_resp.sv
// cv32e40x_lsu_wb_resp
// Load-response assembler between the OBI data interface and write-back.
// Each issued data transaction pushes its attributes into an in-order FIFO.
// Each OBI response pops the head entry. The response data is aligned by
// the address offset. For a misaligned access, the two split parts are
// merged. The merged value is then sign/zero extended by access size.
// The result is registered and held until WB retires the instruction.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   trans_*           transaction push (valid/ready plus attributes)
//   data_rvalid_i     OBI response valid (pops the FIFO head)
//   data_rdata_i      OBI read data
//   data_err_i        OBI bus error
//   kill_i            flush: marks in-flight entries drop, clears state
//   wb_data_req_i     WB holds a valid LSU instruction
//   wb_valid_i        WB retires this cycle (consumes the held result)
//   lsu_rdata_o       assembled, extended load data (registered)
//   lsu_err_o         bus error on any part (registered)
//   lsu_ready_wb_o    WB may retire

module cv32e40x_lsu_wb_resp #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trans_valid_i,
  output logic        trans_ready_o,
  input  logic [1:0]  trans_rshift_i,
  input  logic [1:0]  trans_type_i,
  input  logic        trans_sext_i,
  input  logic        trans_first_i,
  input  logic        trans_last_i,
  input  logic        trans_we_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  input  logic        kill_i,
  input  logic        wb_data_req_i,
  input  logic        wb_valid_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        lsu_ready_wb_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entry layout: {rshift[1:0], type[1:0], sext, first, last, we, drop}
  localparam int E_DROP  = 0;
  localparam int E_WE    = 1;
  localparam int E_LAST  = 2;
  localparam int E_FIRST = 3;
  localparam int E_SEXT  = 4;

  logic [8:0]       fifo_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;
  logic             res_valid_q;
  logic [31:0]      part_q;
  logic             err_q;

  logic             push_s;
  logic             pop_s;
  logic             use_s;
  logic             load_s;
  logic [8:0]       head_s;
  logic [1:0]       head_rshift_s;
  logic [1:0]       head_type_s;
  logic [31:0]      shifted_s;
  logic [31:0]      merged_s;
  logic [31:0]      assembled_s;
  logic [31:0]      extended_s;
  logic [31:0]      result_s;
  logic             err_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + PTR_W'(1);
    end
  endfunction

  // Handshakes; the push is held off while an unconsumed result sits in the output register
  always_comb begin
    trans_ready_o  = (count_r < CNT_W'(DEPTH)) && !(res_valid_q && !wb_valid_i);
    lsu_ready_wb_o = !wb_data_req_i || res_valid_q;
    push_s         = trans_valid_i && trans_ready_o;
    // A response with an empty FIFO is ignored
    pop_s          = data_rvalid_i && (count_r != CNT_W'(0));
  end

  // Head decode, alignment, merge and extension of the response data
  always_comb begin
    head_s        = fifo_r[rptr_r];
    head_rshift_s = head_s[8:7];
    head_type_s   = head_s[6:5];
    use_s         = pop_s && !head_s[E_DROP] && !kill_i;
    load_s        = use_s && head_s[E_LAST];
    shifted_s     = data_rdata_i >> {head_rshift_s, 3'b000};
    // (4 - rshift) mod 4 gives the upper-part shift; rshift 0 maps to no shift
    merged_s      = part_q | (data_rdata_i << {2'(2'd0 - head_rshift_s), 3'b000});
    if (head_s[E_FIRST]) begin
      assembled_s = shifted_s;
      err_s       = data_err_i;
    end else begin
      assembled_s = merged_s;
      err_s       = err_q | data_err_i;
    end
    case (head_type_s)
      2'b00:   extended_s = {{24{assembled_s[7] & head_s[E_SEXT]}}, assembled_s[7:0]};
      2'b01:   extended_s = {{16{assembled_s[15] & head_s[E_SEXT]}}, assembled_s[15:0]};
      2'b10:   extended_s = assembled_s;
      default: extended_s = assembled_s;
    endcase
    if (head_s[E_WE]) begin
      result_s = 32'h0000_0000;
    end else begin
      result_s = extended_s;
    end
  end

  // Transaction-info FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= 9'h000;
      end
    end else begin
      if (kill_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          fifo_r[i][E_DROP] <= 1'b1;
        end
      end
      // A push written after the kill marking keeps drop clear
      if (push_s) begin
        fifo_r[wptr_r] <= {trans_rshift_i, trans_type_i, trans_sext_i,
                           trans_first_i, trans_last_i, trans_we_i, 1'b0};
        wptr_r         <= next_ptr(wptr_r);
      end
      if (pop_s) begin
        rptr_r <= next_ptr(rptr_r);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (!push_s && pop_s) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

  // Partial-part holding, result register and result-valid tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      part_q      <= 32'h0000_0000;
      err_q       <= 1'b0;
      lsu_rdata_o <= 32'h0000_0000;
      lsu_err_o   <= 1'b0;
    end else if (kill_i) begin
      res_valid_q <= 1'b0;
      part_q      <= 32'h0000_0000;
      err_q       <= 1'b0;
    end else begin
      if (use_s && head_s[E_FIRST] && !head_s[E_LAST]) begin
        part_q <= shifted_s;
        err_q  <= data_err_i;
      end
      if (load_s) begin
        res_valid_q <= 1'b1;
        lsu_rdata_o <= result_s;
        lsu_err_o   <= err_s;
      end else if (wb_valid_i && res_valid_q) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  cv32e40x_lsu_wb_resp_chk u_chk (
    .clk           (clk),
    .rst           (rst),
    .data_rvalid_i (data_rvalid_i),
    .fifo_empty    (count_r == CNT_W'(0))
  );

endmodule

// Protocol checker: an OBI response must never arrive with no outstanding entry.
module cv32e40x_lsu_wb_resp_chk (
  input logic clk,
  input logic rst,
  input logic data_rvalid_i,
  input logic fifo_empty
);

  a_no_resp_when_empty: assert property (
    @(posedge clk) disable iff (rst) !(data_rvalid_i && fifo_empty)
  );

endmodule

// File: tb/tb_cv32e40x_lsu_wb_resp.sv
module tb_cv32e40x_lsu_wb_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trans_valid_i = 1'b0;
  logic        trans_ready_o;
  logic [1:0]  trans_rshift_i = 2'd0;
  logic [1:0]  trans_type_i = 2'd0;
  logic        trans_sext_i = 1'b0;
  logic        trans_first_i = 1'b0;
  logic        trans_last_i = 1'b0;
  logic        trans_we_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0;
  logic        data_err_i = 1'b0;
  logic        kill_i = 1'b0;
  logic        wb_data_req_i = 1'b0;
  logic        wb_valid_i = 1'b0;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        lsu_ready_wb_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cv32e40x_lsu_wb_resp #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .trans_valid_i  (trans_valid_i),
    .trans_ready_o  (trans_ready_o),
    .trans_rshift_i (trans_rshift_i),
    .trans_type_i   (trans_type_i),
    .trans_sext_i   (trans_sext_i),
    .trans_first_i  (trans_first_i),
    .trans_last_i   (trans_last_i),
    .trans_we_i     (trans_we_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i),
    .data_err_i     (data_err_i),
    .kill_i         (kill_i),
    .wb_data_req_i  (wb_data_req_i),
    .wb_valid_i     (wb_valid_i),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_err_o      (lsu_err_o),
    .lsu_ready_wb_o (lsu_ready_wb_o)
  );

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] rs, input logic [1:0] ty, input logic sx,
                      input logic fi, input logic la, input logic we);
    trans_valid_i  = 1'b1;
    trans_rshift_i = rs;
    trans_type_i   = ty;
    trans_sext_i   = sx;
    trans_first_i  = fi;
    trans_last_i   = la;
    trans_we_i     = we;
    tick();
    trans_valid_i  = 1'b0;
  endtask

  task automatic resp(input logic [31:0] rd, input logic er);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rd;
    data_err_i    = er;
    tick();
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
  endtask

  task automatic consume();
    wb_valid_i = 1'b1;
    tick();
    wb_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_data_req_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (lsu_rdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h expected %h", lsu_rdata_o, 32'h0);
    end
    tests_run++;
    if (lsu_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_err: got %b expected 0", lsu_err_o);
    end
    tests_run++;
    if (trans_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_trans_ready: got %b expected 1", trans_ready_o);
    end
    tests_run++;
    if (lsu_ready_wb_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_wb_noreq: got %b expected 1", lsu_ready_wb_o);
    end
    wb_data_req_i = 1'b1;
    #1;
    tests_run++;
    if (lsu_ready_wb_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_wb_req: got %b expected 0", lsu_ready_wb_o);
    end
  endtask

  task automatic test_aligned_word();
    push(2'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (lsu_ready_wb_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL word_not_ready_before_resp: got %b expected 0", lsu_ready_wb_o);
    end
    resp(32'hDEADBEEF, 1'b0);
    tests_run++;
    if (lsu_rdata_o !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL word_rdata: got %h expected %h", lsu_rdata_o, 32'hDEADBEEF);
    end
    tests_run++;
    if (lsu_ready_wb_o !== 1'b1 || lsu_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL word_ready_err: got ready=%b err=%b expected ready=1 err=0",
               lsu_ready_wb_o, lsu_err_o);
    end
    consume();
    tests_run++;
    if (lsu_ready_wb_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL word_consumed: got ready=%b expected 0", lsu_ready_wb_o);
    end
  endtask

  task automatic test_byte_ext();
    push(2'd2, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    resp(32'h00800000, 1'b0);
    tests_run++;
    if (lsu_rdata_o !== 32'hFFFFFF80) begin
      tests_failed++;
      $display("FAIL byte_signed: got %h expected %h", lsu_rdata_o, 32'hFFFFFF80);
    end
    consume();
    push(2'd2, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    resp(32'h00800000, 1'b0);
    tests_run++;
    if (lsu_rdata_o !== 32'h00000080) begin
      tests_failed++;
      $display("FAIL byte_unsigned: got %h expected %h", lsu_rdata_o, 32'h00000080);
    end
    consume();
  endtask

  task automatic test_misaligned_word();
    push(2'd1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    push(2'd1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    resp(32'h33221100, 1'b0);
    tests_run++;
    if (lsu_ready_wb_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL misword_first_not_ready: got %b expected 0", lsu_ready_wb_o);
    end
    resp(32'h77665544, 1'b0);
    tests_run++;
    if (lsu_rdata_o !== 32'h44332211 || lsu_ready_wb_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL misword_rdata: got %h ready=%b expected %h ready=1",
               lsu_rdata_o, lsu_ready_wb_o, 32'h44332211);
    end
    consume();
  endtask

  task automatic test_misaligned_half();
    push(2'd3, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    push(2'd3, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    resp(32'hAB000000, 1'b0);
    resp(32'h000000CD, 1'b0);
    tests_run++;
    if (lsu_rdata_o !== 32'hFFFFCDAB || lsu_err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL mishalf_rdata: got %h err=%b expected %h err=0",
               lsu_rdata_o, lsu_err_o, 32'hFFFFCDAB);
    end
    consume();
    push(2'd3, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    push(2'd3, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    resp(32'hAB000000, 1'b1);
    resp(32'h000000CD, 1'b0);
    tests_run++;
    if (lsu_err_o !== 1'b1 || lsu_rdata_o !== 32'hFFFFCDAB) begin
      tests_failed++;
      $display("FAIL mishalf_err: got err=%b data=%h expected err=1 data=%h",
               lsu_err_o, lsu_rdata_o, 32'hFFFFCDAB);
    end
    consume();
  endtask

  task automatic test_store();
    push(2'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
    resp(32'h12345678, 1'b1);
    tests_run++;
    if (lsu_rdata_o !== 32'h0 || lsu_err_o !== 1'b1 || lsu_ready_wb_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL store: got data=%h err=%b ready=%b expected data=0 err=1 ready=1",
               lsu_rdata_o, lsu_err_o, lsu_ready_wb_o);
    end
    consume();
  endtask

  task automatic test_kill();
    push(2'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    push(2'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (trans_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL kill_full_not_ready: got %b expected 0", trans_ready_o);
    end
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    resp(32'h11111111, 1'b0);
    resp(32'h22222222, 1'b0);
    tests_run++;
    if (lsu_ready_wb_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL kill_no_result: got ready=%b expected 0", lsu_ready_wb_o);
    end
    tests_run++;
    if (dut.count_r !== 2'd0) begin
      tests_failed++;
      $display("FAIL kill_count: got %0d expected 0", dut.count_r);
    end
    push(2'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    resp(32'hCAFEF00D, 1'b0);
    tests_run++;
    if (lsu_rdata_o !== 32'hCAFEF00D || lsu_ready_wb_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL kill_after_load: got %h ready=%b expected %h ready=1",
               lsu_rdata_o, lsu_ready_wb_o, 32'hCAFEF00D);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    push(2'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    push(2'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    resp(32'hA5A5A5A5, 1'b0);
    tests_run++;
    if (trans_ready_o !== 1'b0 || lsu_rdata_o !== 32'hA5A5A5A5) begin
      tests_failed++;
      $display("FAIL b2b_held: got ready=%b data=%h expected ready=0 data=%h",
               trans_ready_o, lsu_rdata_o, 32'hA5A5A5A5);
    end
    // Consume, pop the second entry and push a third in one cycle
    wb_valid_i     = 1'b1;
    data_rvalid_i  = 1'b1;
    data_rdata_i   = 32'h5A5A5A5A;
    trans_valid_i  = 1'b1;
    trans_rshift_i = 2'd0;
    trans_type_i   = 2'b10;
    trans_sext_i   = 1'b0;
    trans_first_i  = 1'b1;
    trans_last_i   = 1'b1;
    trans_we_i     = 1'b0;
    #1;
    tests_run++;
    if (trans_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready_on_consume: got %b expected 1", trans_ready_o);
    end
    tick();
    wb_valid_i    = 1'b0;
    data_rvalid_i = 1'b0;
    trans_valid_i = 1'b0;
    tests_run++;
    if (lsu_ready_wb_o !== 1'b1 || lsu_rdata_o !== 32'h5A5A5A5A) begin
      tests_failed++;
      $display("FAIL b2b_reload: got ready=%b data=%h expected ready=1 data=%h",
               lsu_ready_wb_o, lsu_rdata_o, 32'h5A5A5A5A);
    end
    tests_run++;
    if (dut.count_r !== 2'd1) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d expected 1", dut.count_r);
    end
    consume();
    resp(32'h0BADCAFE, 1'b0);
    tests_run++;
    if (lsu_rdata_o !== 32'h0BADCAFE) begin
      tests_failed++;
      $display("FAIL b2b_third: got %h expected %h", lsu_rdata_o, 32'h0BADCAFE);
    end
    consume();
    tests_run++;
    if (lsu_ready_wb_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_final_consume: got %b expected 0", lsu_ready_wb_o);
    end
  endtask

  initial begin
    test_reset();
    test_aligned_word();
    test_byte_ext();
    test_misaligned_word();
    test_misaligned_half();
    test_store();
    test_kill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
